// File: rtl/stim_sequencer.sv
// stim_sequencer: plays a RAM program of {last, rep, data} words onto a DUT input vector, one word per clock.
// Optional macro STIM_SEQ_LOOP_EN adds loop / loop_count for seamless wrap-around playback.
module stim_sequencer #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 101,
  parameter int ADDR_W = 7,
  parameter int REP_W  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [REP_W+DATA_W:0] wr_data,
  input  logic                  run,
  input  logic                  halt,
`ifdef STIM_SEQ_LOOP_EN
  input  logic                  loop,
  output logic [7:0]            loop_count,
`endif
  output logic [DATA_W-1:0]     stim_out,
  output logic                  stim_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [ADDR_W-1:0]     pc_out,
  output logic [15:0]           cycle_count
);

  // state | meaning
  // IDLE  | after reset, outputs cleared, waiting for run
  // RUN   | fetching / holding program words
  // DONE  | program ended or aborted; done (and maybe aborted) held
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam int WORD_W = 1 + REP_W + DATA_W;

  logic [WORD_W-1:0] mem_q [DEPTH];

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [REP_W-1:0]  rep_cnt_q;
  logic              last_loaded_q;
  logic [DATA_W-1:0] stim_out_q;
  logic              stim_valid_q;
  logic              done_q;
  logic              aborted_q;
  logic [ADDR_W-1:0] pc_out_q;
  logic [15:0]       cycle_count_q;

  logic              wr_ok;
  logic              wrap_en;
  logic [ADDR_W-1:0] fetch_addr;
  logic [WORD_W-1:0] fetch_word;
  logic              fetch_last;
  logic [REP_W-1:0]  fetch_rep;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_end;
  logic [15:0]       cycle_inc;

  assign wr_ok = ({1'b0, wr_addr} < (ADDR_W+1)'(DEPTH));

  // Write lands at the edge, so a fetch on that same edge still reads the old word.
  always_ff @(posedge clock) begin
    if (wr_en && wr_ok) mem_q[wr_addr] <= wr_data;
  end

`ifdef STIM_SEQ_LOOP_EN
  logic [7:0] loop_count_q;
  assign wrap_en    = loop;
  assign loop_count = loop_count_q;
`else
  assign wrap_en = 1'b0;
`endif

  // Once the last word has drained, the only legal fetch is the wrap back to word 0.
  assign fetch_addr = last_loaded_q ? '0 : pc_q;
  assign fetch_word = mem_q[fetch_addr];
  assign fetch_last = fetch_word[WORD_W-1];
  assign fetch_rep  = fetch_word[REP_W+DATA_W-1:DATA_W];
  assign fetch_data = fetch_word[DATA_W-1:0];
  assign fetch_end  = fetch_last || (fetch_addr == ADDR_W'(DEPTH-1));
  assign cycle_inc  = (cycle_count_q == 16'hFFFF) ? cycle_count_q : cycle_count_q + 16'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      rep_cnt_q     <= '0;
      last_loaded_q <= 1'b0;
      stim_out_q    <= '0;
      stim_valid_q  <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      pc_out_q      <= '0;
      cycle_count_q <= '0;
`ifdef STIM_SEQ_LOOP_EN
      loop_count_q  <= '0;
`endif
    end else begin
      case (state_q)
        S_RUN: begin
          if (halt) begin
            state_q      <= S_DONE;
            stim_out_q   <= '0;
            stim_valid_q <= 1'b0;
            done_q       <= 1'b1;
            aborted_q    <= 1'b1;
          end else if (rep_cnt_q != '0) begin
            rep_cnt_q     <= rep_cnt_q - REP_W'(1);
            cycle_count_q <= cycle_inc;
          end else if (!last_loaded_q || wrap_en) begin
            stim_out_q    <= fetch_data;
            rep_cnt_q     <= fetch_rep;
            stim_valid_q  <= 1'b1;
            pc_out_q      <= fetch_addr;
            last_loaded_q <= fetch_end;
            cycle_count_q <= cycle_inc;
            if (!fetch_end) pc_q <= fetch_addr + ADDR_W'(1);
`ifdef STIM_SEQ_LOOP_EN
            if (last_loaded_q) loop_count_q <= loop_count_q + 8'd1;
`endif
          end else begin
            state_q      <= S_DONE;
            stim_out_q   <= '0;
            stim_valid_q <= 1'b0;
            done_q       <= 1'b1;
          end
        end
        default: begin
          if (run && !halt) begin
            state_q       <= S_RUN;
            pc_q          <= '0;
            rep_cnt_q     <= '0;
            last_loaded_q <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
            cycle_count_q <= '0;
          end
        end
      endcase
    end
  end

  assign stim_out    = stim_out_q;
  assign stim_valid  = stim_valid_q;
  assign busy        = (state_q == S_RUN);
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign pc_out      = pc_out_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_stim_sequencer.sv
// tb_stim_sequencer: directed and randomized checks of stim_sequencer against a word/repeat playback model.
module tb_stim_sequencer;
  localparam int DATA_W = 6;
  localparam int DEPTH  = 101;
  localparam int ADDR_W = 7;
  localparam int REP_W  = 4;
  localparam int WORD_W = 1 + REP_W + DATA_W;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [WORD_W-1:0] wr_data = '0;
  logic              run = 1'b0;
  logic              halt = 1'b0;
  logic [DATA_W-1:0] stim_out;
  logic              stim_valid, busy, done, aborted;
  logic [ADDR_W-1:0] pc_out;
  logic [15:0]       cycle_count;
`ifdef STIM_SEQ_LOOP_EN
  logic              loop = 1'b0;
  logic [7:0]        loop_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clock = ~clock;

  stim_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .REP_W(REP_W)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .run(run), .halt(halt),
`ifdef STIM_SEQ_LOOP_EN
    .loop(loop), .loop_count(loop_count),
`endif
    .stim_out(stim_out), .stim_valid(stim_valid), .busy(busy), .done(done),
    .aborted(aborted), .pc_out(pc_out), .cycle_count(cycle_count)
  );

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Playback model: a "next word address" plus "extra cycles still to hold".
  int m_mem [DEPTH];
  bit m_busy, m_valid, m_done, m_ab;
  int m_out, m_pc, m_cnt, m_hold, m_next, m_loops;

  task automatic m_load(input int a);
    int w, rep, last;
    w    = m_mem[a];
    rep  = (w >> DATA_W) % (1 << REP_W);
    last = (w >> (DATA_W + REP_W)) & 1;
    m_out   = w % (1 << DATA_W);
    m_pc    = a;
    m_hold  = rep;
    m_valid = 1'b1;
    if (m_cnt < 65535) m_cnt++;
    m_next = (last != 0 || a == DEPTH - 1) ? -1 : a + 1;
  endtask

  always @(posedge clock) begin
    bit lp;
    lp = 1'b0;
`ifdef STIM_SEQ_LOOP_EN
    lp = loop;
`endif
    if (reset) begin
      m_busy = 0; m_valid = 0; m_done = 0; m_ab = 0;
      m_out = 0; m_pc = 0; m_cnt = 0; m_hold = 0; m_next = -1; m_loops = 0;
    end else if (!m_busy) begin
      if (run && !halt) begin
        m_busy = 1; m_done = 0; m_ab = 0; m_cnt = 0; m_hold = 0; m_next = 0;
      end
    end else if (halt) begin
      m_busy = 0; m_done = 1; m_ab = 1; m_valid = 0; m_out = 0;
    end else if (m_valid && m_hold > 0) begin
      m_hold--;
      if (m_cnt < 65535) m_cnt++;
    end else if (m_next >= 0) begin
      m_load(m_next);
    end else if (lp) begin
      m_loops = (m_loops + 1) % 256;
      m_load(0);
    end else begin
      m_busy = 0; m_done = 1; m_valid = 0; m_out = 0;
    end
    if (wr_en && int'(wr_addr) < DEPTH) m_mem[int'(wr_addr)] = int'(wr_data);
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("stim_valid", stim_valid, m_valid);
      check("stim_out", stim_out, m_out);
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("aborted", aborted, m_ab);
      check("cycle_count", cycle_count, m_cnt);
      if (m_valid) check("pc_out", pc_out, m_pc);
`ifdef STIM_SEQ_LOOP_EN
      check("loop_count", loop_count, m_loops);
`endif
    end
  end

  task automatic write(input int a, input logic [WORD_W-1:0] d);
    wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = d;
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  task automatic run_pulse();
    run = 1'b1;
    @(negedge clock);
    run = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int limit);
    for (int i = 0; i < limit && !done; i++) @(negedge clock);
    check(nm, done, 1);
  endtask

  initial begin
    int t1_exp [5];
    int t5_exp [5];
    int nv, lastpc;
    logic [WORD_W-1:0] w;

    t1_exp = '{5, 10, 10, 10, 63};
    repeat (3) @(negedge clock);
    chk_en = 1'b1;
    check("rst_stim_out", stim_out, 0);
    check("rst_valid", stim_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pc_out", pc_out, 0);
    check("rst_cycle_count", cycle_count, 0);
    reset = 1'b0;

    // three-word program with a repeated middle word
    write(0, {1'b0, 4'd0, 6'h05});
    write(1, {1'b0, 4'd2, 6'h0A});
    write(2, {1'b1, 4'd0, 6'h3F});
    run_pulse();
    check("t1_busy_after_e0", busy, 1);
    check("t1_no_word_yet", stim_valid, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("t1_seq_out", stim_out, t1_exp[i]);
      check("t1_seq_valid", stim_valid, 1);
    end
    @(negedge clock);
    check("t1_done", done, 1);
    check("t1_cycle_count", cycle_count, 5);
    check("t1_out_zero", stim_out, 0);
    check("t1_model_cnt", m_cnt, 5);

    // full-depth program, terminates at DEPTH-1 without a last marker
    for (int a = 0; a < DEPTH; a++) write(a, {1'b0, 4'd0, 6'(a)});
    run_pulse();
    nv = 0; lastpc = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clock);
      if (stim_valid) begin nv++; lastpc = int'(pc_out); end
    end
    check("t2_done", done, 1);
    check("t2_valid_cycles", nv, DEPTH);
    check("t2_last_pc", lastpc, DEPTH - 1);
    check("t2_cycle_count", cycle_count, 101);

    // halt on the third cycle of a long-held word
    write(0, {1'b1, 4'hF, 6'h2A});
    run_pulse();
    repeat (3) @(negedge clock);
    check("t3_valid_before_halt", stim_valid, 1);
    halt = 1'b1;
    @(negedge clock);
    halt = 1'b0;
    check("t3_valid", stim_valid, 0);
    check("t3_out", stim_out, 0);
    check("t3_done", done, 1);
    check("t3_aborted", aborted, 1);
    check("t3_cycle_count", cycle_count, 3);

    // reset clears sticky flags; run+halt together does not start
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("t4_rst_done", done, 0);
    check("t4_rst_aborted", aborted, 0);
    run = 1'b1; halt = 1'b1;
    @(negedge clock);
    check("t4_run_halt_busy", busy, 0);
    halt = 1'b0;
    @(negedge clock);
    run = 1'b0;
    check("t4_run_busy", busy, 1);
    repeat (3) @(negedge clock);
    run_pulse();
    check("t4_still_busy", busy, 1);
    wait_done("t4_done", 40);

    // writes during a run: same-edge write is not seen, earlier write is
    t5_exp = '{1, 2, 2, 51, 4};
    write(0, {1'b0, 4'd0, 6'h01});
    write(1, {1'b0, 4'd1, 6'h02});
    write(2, {1'b0, 4'd0, 6'h03});
    write(3, {1'b1, 4'd0, 6'h04});
    run_pulse();
    @(negedge clock);
    check("t5_w0", stim_out, t5_exp[0]);
    wr_en = 1'b1; wr_addr = 7'd1; wr_data = {1'b0, 4'd0, 6'h2B};
    @(negedge clock);
    check("t5_w1_old", stim_out, t5_exp[1]);
    wr_addr = 7'd2; wr_data = {1'b0, 4'd0, 6'h33};
    @(negedge clock);
    wr_en = 1'b0;
    check("t5_w1_hold", stim_out, t5_exp[2]);
    @(negedge clock);
    check("t5_w2_new", stim_out, t5_exp[3]);
    @(negedge clock);
    check("t5_w3", stim_out, t5_exp[4]);
    wait_done("t5_done", 10);

`ifdef STIM_SEQ_LOOP_EN
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    write(0, {1'b0, 4'd0, 6'h11});
    write(1, {1'b1, 4'd0, 6'h22});
    loop = 1'b1;
    run_pulse();
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("loop_out", stim_out, (i % 2 == 0) ? 17 : 34);
      check("loop_count_step", loop_count, i / 2);
      check("loop_done_low", done, 0);
    end
    loop = 1'b0;
    @(negedge clock);
    check("loop_end_done", done, 1);
    check("loop_end_valid", stim_valid, 0);
`endif

    // randomized programs with random run/halt/write/reset traffic
    for (int r = 0; r < 40; r++) begin
      int len;
      len = $urandom_range(1, 12);
      for (int a = 0; a < len; a++) begin
        w = {1'b0, 4'($urandom_range(0, 3)), 6'($urandom)};
        w[WORD_W-1] = (a == len - 1) || ($urandom_range(0, 7) == 0);
        write(a, w);
      end
      run_pulse();
      for (int c = 0; c < 50; c++) begin
        run   = ($urandom_range(0, 9) == 0);
        halt  = ($urandom_range(0, 39) == 0);
        reset = ($urandom_range(0, 199) == 0);
        wr_en = ($urandom_range(0, 7) == 0);
        wr_addr = 7'($urandom_range(0, 127));
        wr_data = 11'($urandom);
        @(negedge clock);
      end
      run = 1'b0; halt = 1'b0; reset = 1'b0; wr_en = 1'b0;
    end
    @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
